alu_input_sequencer: RTL
========================

# alu_input_sequencer

Front-end controller that drives the lab ALU's operand-entry interface from raw board controls. It debounces the active-low load and equal push buttons. It sequences entry of operand A, operand B and the result request, and presents the ALU with held `number` and `op` values and clean single-cycle active-low `load`/`equal` strobes. It sits between the board pins and the ALU's `number`, `mux1..mux4`, `load` and `equal` inputs.

## Interface
- `N`, default 4: operand width.
- `DEB_CYCLES`, default 500000: consecutive stable cycles required to accept a button level change. Minimum 2.
- `clk`  in  1: system clock.
- `rst`  in  1: reset. Asynchronous and active-low.
- `btn_load`  in  1: raw load push button, active-low, asynchronous to `clk`.
- `btn_equal`  in  1: raw equal push button, active-low, asynchronous to `clk`.
- `sw_number`  in  N: operand switches.
- `sw_op`  in  4: operation switches; bit 0..3 feed `mux1..mux4`.
- `number`  out  N: registered operand for the ALU.
- `op`  out  4: registered operation select; `op[0]` drives `mux1`, `op[3]` drives `mux4`.
- `load`  out  1: active-low strobe, low for exactly one cycle per accepted operand.
- `equal`  out  1: active-low strobe, low for exactly one cycle per accepted result request.
- `stage`  out  2: entry state for LEDs. 0 = IDLE, 1 = A_LOADED, 2 = B_LOADED, 3 = RESULT.

## Operation
- Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debouncer keeps a stable level, which resets to 1 (released).
  - A counter increments while the synchronized level differs from the stable level and clears when they match.
  - When the counter reaches `DEB_CYCLES`, the stable level flips and the counter clears.
  - A stable 1->0 transition produces a one-cycle `press` strobe.
  - A release produces no strobe.
- FSM states are IDLE, A_LOADED, B_LOADED and RESULT.
  - IDLE, load press: `number` <= `sw_number`, pulse `load`, go to A_LOADED.
  - A_LOADED, load press: `number` <= `sw_number`, pulse `load`, go to B_LOADED.
  - B_LOADED, equal press: `op` <= `sw_op`, pulse `equal`, go to RESULT.
  - RESULT, load press: `number` <= `sw_number`, pulse `load`, go to A_LOADED. This starts a new calculation.
- Ignored events:
  - An equal press in IDLE, A_LOADED or RESULT.
  - A load press in B_LOADED.
  - An ignored event produces no strobe and no register update.
- Simultaneous load and equal press in the same cycle:
  - In B_LOADED, equal wins and load is dropped.
  - In all other states, load wins.
- `number` and `op` hold their values between captures. Switch changes between presses do not propagate.
- `load` and `equal` are never low in the same cycle.
- `load` and `equal` are never low on two consecutive cycles. At least `DEB_CYCLES` cycles separate two presses of one button.

## Timing
- Values after reset, asynchronous on `rst` low:
  - `number` = 0, `op` = 0, `load` = 1, `equal` = 1, `stage` = 0.
  - Synchronizer flops = 1, debouncer stable levels = 1, debouncer counters = 0.
- Reset asserted mid-debounce or mid-strobe aborts immediately.
  - No strobe is emitted after `rst` deasserts until a fresh press is accepted.
- Latency from the first rising edge that samples the button low to `press`: 2 synchronizer cycles + `DEB_CYCLES` count cycles.
- `load`/`equal` go low, and `number`/`op`/`stage` update, on the edge after `press`.
  - These registered outputs change together on the same edge.
  - `number` is therefore valid in the same cycle `load` is low.
- Bounce shorter than `DEB_CYCLES` cycles clears the counter and never produces a press.
- A button held low produces exactly one press. A new press requires a release and then a new low level, each accepted by the debouncer.
- The debounce counter width is $clog2(`DEB_CYCLES`+1). It saturates and does not wrap.

## Structure
- Package `alu_ui_pkg` holds:
  - the `entry_state_t` enum (IDLE=2'd0, A_LOADED=2'd1, B_LOADED=2'd2, RESULT=2'd3), so that `stage` equals the state encoding;
  - `OP_W` = 4.
- Sub-module `btn_debounce` (parameter `DEB_CYCLES`; ports `clk`, `rst`, `btn_n`, `press`) contains the synchronizer, counter, stable level and falling-edge strobe. It is instantiated twice.
- The top level contains the FSM and the output registers.

## Test plan
- All scenarios use `DEB_CYCLES`=4.
- Reset: drive `rst`=0 with buttons at 1 -> `number`=0, `op`=0, `load`=1, `equal`=1, `stage`=0, with no clock edge required.
- Full sequence:
  - `sw_number`=4'b1011, `btn_load` low for 10 cycles -> `load` low for exactly 1 cycle with `number`=4'b1011, `stage`=1.
  - Release, then `sw_number`=4'b0111, press load -> `load` pulse, `number`=4'b0111, `stage`=2.
  - `sw_op`=4'b0010, press equal -> `equal` pulse, `op`=4'b0010, `stage`=3.
- Bounce rejection: `btn_load` toggles every 2 cycles for 20 cycles, then returns to 1 -> no `load` pulse, `stage` unchanged.
- Illegal events:
  - Equal press in IDLE -> no `equal` pulse, `stage`=0.
  - Load press in B_LOADED -> no `load` pulse, `number` unchanged, `stage`=2.
- Simultaneous presses:
  - Both buttons low on the same cycle in B_LOADED -> `equal` pulse only, `stage`=3.
  - Both buttons low on the same cycle in RESULT -> `load` pulse only, `stage`=1.
- Held button and reset: hold `btn_load` low for 50 cycles -> exactly one `load` pulse. Assert `rst` while the counter is mid-count on a second press -> outputs return to reset values and no pulse follows deassertion.

Source files
------------

// File: rtl/alu_ui_pkg.sv
// Shared types and constants for the ALU operand-entry front end.
//   entry_state_t : operand-entry FSM state; its encoding is what the
//                   board LEDs show on the stage output.
//   OP_W          : width of the ALU operation-select bus (mux1..mux4).
package alu_ui_pkg;

  localparam int OP_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    A_LOADED = 2'd1,
    B_LOADED = 2'd2,
    RESULT   = 2'd3
  } entry_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: a 2-FF synchronizer, a stable-level debouncer
// and a falling-edge strobe generator for one active-low button.
//   clk   : system clock
//   rst   : asynchronous, active-low reset
//   btn_n : raw button level, active-low, asynchronous to clk
//   press : one-cycle high strobe when the debounced level goes 1 -> 0
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  // Value the counter holds on the cycle whose increment reaches DEB_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // NOTE: every flop here is cleared by the async reset, including the
  // synchronizer, so a reset mid-debounce leaves no partial count behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync2_q take the old sync1_q,
      // giving a true two-stage synchronizer.
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == stable_q) begin
        // Any bounce back to the stable level discards the partial count.
        cnt_q <= '0;
      end else if (cnt_q >= CNT_LAST) begin
        // Count reaches DEB_CYCLES: accept the new level. Only a released
        // (1) to pressed (0) change is reported; releases stay silent.
        stable_q <= sync2_q;
        cnt_q    <= '0;
        press_q  <= stable_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// Front-end controller for the lab ALU operand-entry interface. Debounces
// the load/equal buttons, walks A -> B -> result entry, and drives held
// number/op values with single-cycle active-low load/equal strobes.
//   clk, rst             : clock, asynchronous active-low reset
//   btn_load, btn_equal  : raw active-low push buttons
//   sw_number [N-1:0]    : operand switches
//   sw_op [3:0]          : operation switches (bit 0 -> mux1 .. bit 3 -> mux4)
//   number [N-1:0]       : registered operand for the ALU
//   op [3:0]             : registered operation select
//   load, equal          : active-low one-cycle strobes
//   stage [1:0]          : entry state for LEDs (IDLE/A_LOADED/B_LOADED/RESULT)
module alu_input_sequencer
  import alu_ui_pkg::*;
#(
  parameter int N          = 4,
  parameter int DEB_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_load,
  input  logic            btn_equal,
  input  logic [N-1:0]    sw_number,
  input  logic [OP_W-1:0] sw_op,
  output logic [N-1:0]    number,
  output logic [OP_W-1:0] op,
  output logic            load,
  output logic            equal,
  output logic [1:0]      stage
);

  logic load_press;
  logic equal_press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_load),
    .press (load_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_equal (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_equal),
    .press (equal_press)
  );

  entry_state_t    state_q;
  logic [N-1:0]    number_q;
  logic [OP_W-1:0] op_q;
  logic            load_q;
  logic            equal_q;

  // All outputs are registered in the same block so number/op/stage and
  // the strobe change on the same edge; number is valid while load is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      number_q <= '0;
      op_q     <= '0;
      load_q   <= 1'b1;
      equal_q  <= 1'b1;
    end else begin
      load_q  <= 1'b1;
      equal_q <= 1'b1;
      case (state_q)
        // IDLE and RESULT both start a new calculation on load; equal is
        // ignored, so a simultaneous press resolves to load here.
        IDLE, RESULT: begin
          if (load_press) begin
            number_q <= sw_number;
            load_q   <= 1'b0;
            state_q  <= A_LOADED;
          end
        end
        A_LOADED: begin
          if (load_press) begin
            number_q <= sw_number;
            load_q   <= 1'b0;
            state_q  <= B_LOADED;
          end
        end
        // Only equal is meaningful here; load is dropped even if simultaneous.
        B_LOADED: begin
          if (equal_press) begin
            op_q    <= sw_op;
            equal_q <= 1'b0;
            state_q <= RESULT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign number = number_q;
  assign op     = op_q;
  assign load   = load_q;
  assign equal  = equal_q;
  assign stage  = state_q;

endmodule
